// File: rtl/adder_seq_nbit.sv
// adder_seq_nbit: multi-cycle ripple adder/subtractor.
// Adds WIDTH-bit operands CHUNK bits per clock, carrying between chunks
// through a register. Valid/ready handshakes on both sides. Subtract is
// done as A + ~B + 1 (borrow-in folded into the carry register), and
// carry/overflow/zero flags are produced with the final chunk.
module adder_seq_nbit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inCarry,
  input  logic             inSub,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outSum,
  output logic             outCarry,
  output logic             outOverflow,
  output logic             outZero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Refuse to build with a chunk size that does not tile the operand.
  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("adder_seq_nbit: need WIDTH >= 2 and CHUNK dividing WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // operand A
  logic [WIDTH-1:0] b_q, b_d;       // operand B, already inverted for subtract
  logic             c_q, c_d;       // ripple carry between chunks
  logic [CW-1:0]    cnt_q, cnt_d;   // index of the chunk processed next
  logic [WIDTH-1:0] sum_q, sum_d;   // result, filled one chunk per cycle
  logic             zacc_q, zacc_d; // running "all result bits zero so far"
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Chunk views of the operands so the active chunk is a plain mux.
  logic [CHUNK-1:0] a_chunk [N];
  logic [CHUNK-1:0] b_chunk [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chunk
      assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  logic [CHUNK-1:0] a_cur, b_cur;
  logic [CHUNK:0]   chunk_full;
  logic             chunk_zero;
  logic             msb_cin;

  // One chunk of the ripple add, plus the carry into the chunk's top bit
  // (needed for signed overflow when this is the most significant chunk).
  always_comb begin
    a_cur      = a_chunk[cnt_q];
    b_cur      = b_chunk[cnt_q];
    chunk_full = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, c_q};
    chunk_zero = (chunk_full[CHUNK-1:0] == '0);
    msb_cin    = a_cur[CHUNK-1] ^ b_cur[CHUNK-1] ^ chunk_full[CHUNK-1];
  end

  // Next-state and datapath update for IDLE -> RUN -> DONE sequencing.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    zacc_d  = zacc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (inValid) begin
          a_d     = inA;
          b_d     = inSub ? ~inB : inB;
          c_d     = inCarry ^ inSub;
          cnt_d   = '0;
          zacc_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) begin
            sum_d[i*CHUNK +: CHUNK] = chunk_full[CHUNK-1:0];
          end
        end
        c_d    = chunk_full[CHUNK];
        cnt_d  = cnt_q + 1'b1;
        zacc_d = zacc_q & chunk_zero;
        if (cnt_q == LAST) begin
          carry_d = chunk_full[CHUNK];
          ovf_d   = msb_cin ^ chunk_full[CHUNK];
          zero_d  = zacc_q & chunk_zero;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (outReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      zacc_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      zacc_q  <= zacc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // inReady is masked by rst so nothing looks acceptable during reset.
  assign inReady     = (state_q == IDLE) && !rst;
  assign outValid    = (state_q == DONE);
  assign outSum      = sum_q;
  assign outCarry    = carry_q;
  assign outOverflow = ovf_q;
  assign outZero     = zero_q;

endmodule

// File: tb/tb_adder_seq_nbit.sv
// tb_adder_seq_nbit: directed scoreboard bench for adder_seq_nbit.
// Main instance is 32/8 (N=4); two 16-bit instances cover N=1 and N=16.
module tb_adder_seq_nbit;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  exp_t sb_q[$];
  exp_t sb16_q[$];

  // main DUT (WIDTH=32, CHUNK=8)
  logic        in_valid, in_ready, in_carry, in_sub;
  logic [31:0] in_a, in_b, out_sum;
  logic        out_valid, out_ready, out_carry, out_ovf, out_zero;

  // N=1 DUT (WIDTH=16, CHUNK=16)
  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [15:0] p_in_a, p_in_b, p_out_sum;
  logic        p_out_carry, p_out_ovf, p_out_zero;

  // N=16 DUT (WIDTH=16, CHUNK=1)
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [15:0] s_in_a, s_in_b, s_out_sum;
  logic        s_out_carry, s_out_ovf, s_out_zero;

  logic        zero_bit = 1'b0;

  adder_seq_nbit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .inValid(in_valid), .inReady(in_ready),
    .inA(in_a), .inB(in_b), .inCarry(in_carry), .inSub(in_sub),
    .outValid(out_valid), .outReady(out_ready), .outSum(out_sum),
    .outCarry(out_carry), .outOverflow(out_ovf), .outZero(out_zero)
  );

  adder_seq_nbit #(.WIDTH(16), .CHUNK(16)) dut_p (
    .clk(clk), .rst(rst), .inValid(p_in_valid), .inReady(p_in_ready),
    .inA(p_in_a), .inB(p_in_b), .inCarry(zero_bit), .inSub(zero_bit),
    .outValid(p_out_valid), .outReady(p_out_ready), .outSum(p_out_sum),
    .outCarry(p_out_carry), .outOverflow(p_out_ovf), .outZero(p_out_zero)
  );

  adder_seq_nbit #(.WIDTH(16), .CHUNK(1)) dut_s (
    .clk(clk), .rst(rst), .inValid(s_in_valid), .inReady(s_in_ready),
    .inA(s_in_a), .inB(s_in_b), .inCarry(zero_bit), .inSub(zero_bit),
    .outValid(s_out_valid), .outReady(s_out_ready), .outSum(s_out_sum),
    .outCarry(s_out_carry), .outOverflow(s_out_ovf), .outZero(s_out_zero)
  );

  // Whole-word reference: A + (sub ? ~B : B) + (cin ^ sub), modulo 2^w.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t        r;
    logic [32:0] full;
    logic [31:0] mask, am, bm;
    mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am     = a & mask;
    bm     = (sub ? ~b : b) & mask;
    full   = {1'b0, am} + {1'b0, bm} + {32'd0, cin ^ sub};
    r.sum  = full[31:0] & mask;
    r.carry = full[w];
    r.ovf  = (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, "_sum"},   out_sum,   e.sum);
    check({tag, "_carry"}, {31'd0, out_carry}, {31'd0, e.carry});
    check({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, e.ovf});
    check({tag, "_zero"},  {31'd0, out_zero},  {31'd0, e.zero});
  endtask

  // Present a request and hold it until accepted; push the expected result.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
    int k;
    @(negedge clk);
    in_a = a; in_b = b; in_carry = cin; in_sub = sub; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept_wait", {31'd0, (k < 50)}, 32'd1);
    sb_q.push_back(model(32, a, b, cin, sub));
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    in_carry = ~cin;
    in_sub = ~sub;
  endtask

  // Count cycles from the acceptance edge until outValid is seen.
  task automatic wait_done(input int exp_lat);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, exp_lat);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, {31'd0, (sb_q.size() != 0)}, 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_out(tag, e);
      $display("%s: sum=0x%08h c=%0b v=%0b z=%0b (exp 0x%08h %0b %0b %0b)", tag,
               out_sum, out_carry, out_ovf, out_zero, e.sum, e.carry, e.ovf, e.zero);
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("retire_valid_low", {31'd0, out_valid}, 32'd0);
    check("retire_ready_high", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub);
    start_op(a, b, cin, sub);
    wait_done(4);
    check_result(tag);
    retire();
  endtask

  // One add on a 16-bit instance: which=0 -> N=1, which=1 -> N=16.
  task automatic run16(input string tag, input int which, input logic [15:0] a,
                       input logic [15:0] b, input int exp_lat);
    int   k, cyc;
    exp_t e;
    logic rdy, vld;
    @(negedge clk);
    if (which == 0) begin p_in_a = a; p_in_b = b; p_in_valid = 1'b1; end
    else            begin s_in_a = a; s_in_b = b; s_in_valid = 1'b1; end
    k = 0;
    rdy = (which == 0) ? p_in_ready : s_in_ready;
    while (!rdy && k < 50) begin
      @(negedge clk);
      k++;
      rdy = (which == 0) ? p_in_ready : s_in_ready;
    end
    check({tag, "_accept_wait"}, {31'd0, (k < 50)}, 32'd1);
    sb16_q.push_back(model(16, {16'd0, a}, {16'd0, b}, 1'b0, 1'b0));
    @(negedge clk);
    p_in_valid = 1'b0; s_in_valid = 1'b0;
    cyc = 0;
    vld = (which == 0) ? p_out_valid : s_out_valid;
    while (!vld && cyc < 100) begin
      @(negedge clk);
      cyc++;
      vld = (which == 0) ? p_out_valid : s_out_valid;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_sb_nonempty"}, {31'd0, (sb16_q.size() != 0)}, 32'd1);
    if (sb16_q.size() != 0) begin
      e = sb16_q.pop_front();
      if (which == 0) begin
        check({tag, "_sum"},   {16'd0, p_out_sum}, e.sum);
        check({tag, "_carry"}, {31'd0, p_out_carry}, {31'd0, e.carry});
        check({tag, "_ovf"},   {31'd0, p_out_ovf},   {31'd0, e.ovf});
        check({tag, "_zero"},  {31'd0, p_out_zero},  {31'd0, e.zero});
        $display("%s: sum=0x%04h c=%0b v=%0b z=%0b", tag, p_out_sum, p_out_carry, p_out_ovf, p_out_zero);
      end else begin
        check({tag, "_sum"},   {16'd0, s_out_sum}, e.sum);
        check({tag, "_carry"}, {31'd0, s_out_carry}, {31'd0, e.carry});
        check({tag, "_ovf"},   {31'd0, s_out_ovf},   {31'd0, e.ovf});
        check({tag, "_zero"},  {31'd0, s_out_zero},  {31'd0, e.zero});
        $display("%s: sum=0x%04h c=%0b v=%0b z=%0b", tag, s_out_sum, s_out_carry, s_out_ovf, s_out_zero);
      end
    end
    p_out_ready = 1'b1; s_out_ready = 1'b1;
    @(negedge clk);
    p_out_ready = 1'b0; s_out_ready = 1'b0;
    vld = (which == 0) ? p_out_valid : s_out_valid;
    check({tag, "_retire"}, {31'd0, vld}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_carry = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    p_in_valid = 1'b0; p_in_a = '0; p_in_b = '0; p_out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_out_ready = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_flags", {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
    check("rst_p_in_ready", {31'd0, p_in_ready}, 32'd0);
    check("rst_s_in_ready", {31'd0, s_in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // 1. basic add, latency N=4
    start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(4);
    check("t1_sum_const", out_sum, 32'h0001_0000);
    check_result("t1_add");
    retire();

    // 2. wrap and signed overflow
    run_op("t2_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("t2_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

    // 3. subtract
    run_op("t3_7m5",     32'd7,           32'd5, 1'b0, 1'b1);
    run_op("t3_5m7",     32'd5,           32'd7, 1'b0, 1'b1);
    run_op("t3_minm1",   32'h8000_0000,   32'd1, 1'b0, 1'b1);
    run_op("t3_7m5_bin", 32'd7,           32'd5, 1'b1, 1'b1);
    run_op("t3_add_cin", 32'h1234_00FF,   32'h0000_0001, 1'b1, 1'b0);

    // outReady high before DONE has no effect until the result is valid
    out_ready = 1'b1;
    start_op(32'h0000_0012, 32'h0000_0034, 1'b0, 1'b0);
    wait_done(4);
    check_result("early_ready");
    retire();

    // 4. backpressure in DONE with noisy request inputs
    start_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0);
    wait_done(4);
    e = sb_q[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_a = $urandom;
      in_b = $urandom;
      #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_out("bp_hold", e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_result("t4_bp");
    retire();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_no_ghost", {31'd0, out_valid}, 32'd0);
    end
    run_op("t4_next", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);

    // 5. asynchronous reset mid-RUN, after E2
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_sum", out_sum, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_flags", {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_release_ready", {31'd0, in_ready}, 32'd1);
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_done(4);
    check("t5_sum_const", out_sum, 32'h2345_6789);
    check_result("t5_after_rst");
    retire();

    // 6. extreme chunkings on 16-bit instances
    run16("t6_n1",       0, 16'h8000, 16'h8000, 1);
    run16("t6_n16",      1, 16'h8000, 16'h8000, 16);
    run16("t6_n1_b",     0, 16'h1234, 16'h0FCD, 1);
    run16("t6_n16_b",    1, 16'h7FFF, 16'h0001, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_seq_nbit.md
Name: adder_seq_nbit

Overview:
Parametrised multi-cycle ripple adder/subtractor. It adds WIDTH-bit operands CHUNK bits per clock, rippling the carry through a register between chunks, so wide adds cost little area. Valid/ready handshakes on input and output let it sit as a shared arithmetic resource beside the existing combinational adders. It also provides a subtract mode and carry/overflow/zero flags, which the combinational adders do not.

Parameters:
WIDTH, 32, operand and result width in bits; must be >= 2.
CHUNK, 8, bits processed per cycle; must be >= 1 and divide WIDTH exactly, otherwise elaboration fails.
(Derived: N = WIDTH/CHUNK chunk cycles per operation.)

Ports:
clk  input  1  sole clock, rising edge.
rst  input  1  asynchronous, active-high reset.
inValid  input  1  operation request.
inReady  output  1  block can accept a request.
inA  input  WIDTH  operand A.
inB  input  WIDTH  operand B.
inCarry  input  1  carry-in (add mode) / borrow-in (sub mode).
inSub  input  1  0 = add, 1 = subtract.
outValid  output  1  result available.
outReady  input  1  consumer takes result.
outSum  output  WIDTH  result.
outCarry  output  1  carry-out of MSB (sub mode: 1 = no borrow).
outOverflow  output  1  signed overflow.
outZero  output  1  outSum == 0.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high (clk, rst).
- Reset: while rst=1, state = IDLE and all registers clear. outValid, outSum, outCarry, outOverflow and outZero are 0. inReady is forced to 0 while rst=1.
- FSM states: IDLE, RUN, DONE.
- IDLE: inReady=1, outValid=0.
  - On an edge with inValid & inReady, latch A and B' = inSub ? ~inB : inB.
  - Latch carry register c = inCarry ^ inSub.
  - Clear the chunk counter; go to RUN.
  - Sub mode therefore computes A - B - inCarry.
- RUN: inReady=0, outValid=0.
  - Each edge adds chunk i (bits i*CHUNK+CHUNK-1 : i*CHUNK) of A and B' plus c.
  - Store the chunk sum into the result, update c, increment i.
  - After the edge that processes chunk N-1, go to DONE.
- Latency: the acceptance edge is E0; chunks are processed at E1..EN. outValid is high in the cycle after EN. With N=1, outValid is high after E1.
- Flags, registered at the final chunk:
  - outCarry = carry out of bit WIDTH-1.
  - outOverflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - outZero = 1 iff every result bit is 0, accumulated across chunks.
- DONE: outValid=1, inReady=0.
  - outSum and all flags stay stable until handshake.
  - On an edge with outValid & outReady, go to IDLE. outValid drops next cycle; outSum and flags keep their last values.
  - Throughput: one operation per N+2 cycles minimum.
- inValid while inReady=0 is ignored; no request is queued. Operand inputs are sampled only at acceptance, so later changes have no effect.
- Arithmetic is modulo 2^WIDTH. There are no X outputs after reset.
- Reset asserted in RUN or DONE aborts the operation immediately, with no partial result. After release the block is in IDLE with inReady=1.
- outReady held high before DONE has no effect until outValid=1.

Test Plan:
1. Defaults, add: inA=0x0000FFFF, inB=0x00000001, inCarry=0 -> outSum=0x00010000, outCarry=0, outOverflow=0, outZero=0; outValid first high in the cycle after E4.
2. Add wrap: inA=0xFFFFFFFF, inB=0x00000001 -> outSum=0x00000000, outCarry=1, outZero=1, outOverflow=0. Signed overflow: inA=0x7FFFFFFF, inB=1 -> outSum=0x80000000, outOverflow=1, outCarry=0.
3. Subtract, inSub=1, inCarry=0:
   - 7-5 -> outSum=0x00000002, outCarry=1.
   - 5-7 -> outSum=0xFFFFFFFE, outCarry=0, outOverflow=0.
   - 0x80000000-1 -> outSum=0x7FFFFFFF, outOverflow=1.
   - 7-5 with inCarry=1 -> outSum=0x00000001.
4. Backpressure: hold outReady=0 for 10 cycles in DONE while toggling inA/inValid -> outSum/flags stable, inReady=0, no new acceptance. Then outReady=1 -> IDLE; the next request is accepted with the correct result.
5. Reset mid-RUN: assert rst asynchronously after E2 -> outputs 0 immediately. Release, then issue 0x12345678+0x11111111 -> 0x23456789.
6. WIDTH=16, CHUNK=16 (N=1) and WIDTH=16, CHUNK=1 (N=16): 0x8000+0x8000 -> outSum=0x0000, outCarry=1, outOverflow=1, outZero=1. outValid appears after E1 and E16 respectively.
